mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- E-stage multiply/divide unit for the 5-stage MIPS pipeline; executes mult, multu, div, divu, mfhi, mflo, mthi and mtlo.
- Owns the HI/LO registers and models multi-cycle latency with a busy counter.
- Start and Busy feed the hazard control unit, which stalls D whenever an MD-class instruction is in D while Start|Busy is high.
- MDOut feeds the E-stage result mux for mfhi/mflo.

Parameters:
MULT_CYCLES, 5, Busy duration for mult/multu (>=1)
DIV_CYCLES, 10, Busy duration for div/divu (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
MDOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, others = none
Start  input  1  E-stage instruction is mult/multu/div/divu (decoded upstream)
A  input  32  forwarded rs value (E stage)
B  input  32  forwarded rt value (E stage)
Busy  output  1  operation in flight
HI  output  32  HI register
LO  output  32  LO register
MDOut  output  32  combinational: HI if MDOp==5, LO if MDOp==6, else 0

Behaviour:
- Reset (reset==0, async): HI=0, LO=0, Busy=0, counter=0, pending result cleared. Reset mid-operation aborts the operation; no HI/LO write.
- Idle (Busy==0), Start==1 with MDOp in 1..4, at rising edge T:
  - compute 64-bit result from A/B into internal pending HI/LO;
  - load counter with MULT_CYCLES or DIV_CYCLES;
  - Busy=1 after edge T.
- Busy phase: counter decrements each edge. At edge T+N (N = loaded count), HI/LO take the pending values and Busy falls. Busy is therefore high for exactly N cycles.
- Start while Busy==1: ignored. Hazard control guarantees this never occurs; the bench checks that nothing changes.
- Start==1 with MDOp outside 1..4: ignored.
- mthi/mtlo (MDOp 7/8, Busy==0): HI or LO = A at the next edge; zero latency; Busy stays 0. While Busy==1: ignored.
- mfhi/mflo: MDOut reflects the current register contents combinationally. Stalling guarantees no read while Busy.
- mult: signed 32x32->64. multu: unsigned. HI = upper 32 bits, LO = lower 32 bits.
- div: signed; quotient truncates toward zero; remainder takes the sign of the dividend. LO = quotient, HI = remainder.
  - 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- divu: unsigned. LO = quotient, HI = remainder.
- Divide by zero (B==0, div or divu): Busy still asserted for DIV_CYCLES; HI/LO unchanged at completion.
- A new Start in the same cycle Busy falls is blocked by the stall; the next Start is accepted one edge later.
- Internal datapath uses 64-bit signed/unsigned products and 32-bit quotient/remainder. No multi-cycle algorithm is required; only the latency is modelled.

Test Plan:
- Reset release, then mult A=0xFFFFFFFF B=2 with Start at edge T -> Busy=1 for edges T..T+4; at T+5 HI=0xFFFFFFFF, LO=0xFFFFFFFE, Busy=0.
- multu A=0xFFFFFFFF B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE; MDOp=5 -> MDOut=0x00000001.
- div A=-7 (0xFFFFFFF9) B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu A=7 B=2 -> LO=3, HI=1.
- div A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000, HI=0. Then div with B=0 and prior HI=1, LO=3 -> Busy high for 10 cycles, HI=1 and LO=3 unchanged.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on consecutive cycles -> HI/LO updated on each edge with Busy=0. Issuing Start (mult) while Busy -> pending result and counter unaffected.
- Start mult, pull reset low at cycle 3 of Busy -> Busy, HI and LO all 0 immediately. Release reset -> no late HI/LO write occurs.

Source files
------------

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: owns HI/LO, models fixed
// mult/div latency with a busy counter and commits at the end.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDOp,
  input  logic        Start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] load_cnt;
  logic [31:0]   pend_hi_q;
  logic [31:0]   pend_lo_q;
  logic          pend_wr_q;

  logic op_mult, op_multu, op_div, op_divu;
  logic op_mfhi, op_mflo, op_mthi, op_mtlo;
  logic op_md, accept, commit;

  always_comb begin
    op_mult  = 1'b0;
    op_multu = 1'b0;
    op_div   = 1'b0;
    op_divu  = 1'b0;
    op_mfhi  = 1'b0;
    op_mflo  = 1'b0;
    op_mthi  = 1'b0;
    op_mtlo  = 1'b0;
    unique case (1'b1)
      (MDOp == 4'd1): op_mult  = 1'b1;
      (MDOp == 4'd2): op_multu = 1'b1;
      (MDOp == 4'd3): op_div   = 1'b1;
      (MDOp == 4'd4): op_divu  = 1'b1;
      (MDOp == 4'd5): op_mfhi  = 1'b1;
      (MDOp == 4'd6): op_mflo  = 1'b1;
      (MDOp == 4'd7): op_mthi  = 1'b1;
      (MDOp == 4'd8): op_mtlo  = 1'b1;
      default: ;
    endcase
  end

  assign op_md  = op_mult | op_multu | op_div | op_divu;
  assign accept = (state_q == IDLE) && Start && op_md;
  assign commit = (state_q == RUN) && (cnt_q == CW'(1));

  assign load_cnt = (op_mult | op_multu) ?
    CW'(MULT_CYCLES) : CW'(DIV_CYCLES);

  // Results are computed in one shot; only latency is modelled.
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic               b_zero;
  logic [31:0]        a_mag, b_mag, bs_safe, bu_safe;
  logic [31:0]        q_mag, r_mag, q_s, r_s, q_u, r_u;

  assign prod_s = $signed({{32{A[31]}}, A})
                * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  assign b_zero  = (B == 32'd0);
  assign a_mag   = A[31] ? (~A + 32'd1) : A;
  assign b_mag   = B[31] ? (~B + 32'd1) : B;
  assign bs_safe = b_zero ? 32'd1 : b_mag;
  assign bu_safe = b_zero ? 32'd1 : B;

  // Sign-magnitude division keeps 0x80000000 / -1 well defined.
  assign q_mag = a_mag / bs_safe;
  assign r_mag = a_mag % bs_safe;
  assign q_s   = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s   = A[31] ? (~r_mag + 32'd1) : r_mag;
  assign q_u   = A / bu_safe;
  assign r_u   = A % bu_safe;

  logic [31:0] res_hi, res_lo;
  logic        res_wr;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_wr = 1'b0;
    unique case (1'b1)
      op_mult: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
        res_wr = 1'b1;
      end
      op_multu: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
        res_wr = 1'b1;
      end
      op_div: begin
        res_hi = r_s;
        res_lo = q_s;
        res_wr = !b_zero;
      end
      op_divu: begin
        res_hi = r_u;
        res_lo = q_u;
        res_wr = !b_zero;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN:  if (commit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
      HI        <= 32'd0;
      LO        <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q     <= load_cnt;
        pend_hi_q <= res_hi;
        pend_lo_q <= res_lo;
        pend_wr_q <= res_wr;
      end else if (state_q == RUN) begin
        cnt_q <= cnt_q - CW'(1);
        if (commit) begin
          pend_wr_q <= 1'b0;
          if (pend_wr_q) begin
            HI <= pend_hi_q;
            LO <= pend_lo_q;
          end
        end
      end else if (op_mthi) begin
        HI <= A;
      end else if (op_mtlo) begin
        LO <= A;
      end
    end
  end

  assign Busy = (state_q == RUN);

  always_comb begin
    MDOut = 32'd0;
    unique case (1'b1)
      op_mfhi: MDOut = HI;
      op_mflo: MDOut = LO;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corners plus random ops,
// scoreboard of expected HI/LO and busy length per operation.
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  MDOp = 4'd0;
  logic        Start = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        Busy;
  logic [31:0] HI, LO, MDOut;

  mult_div_unit #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .MDOp (MDOp),
    .Start(Start),
    .A    (A),
    .B    (B),
    .Busy (Busy),
    .HI   (HI),
    .LO   (LO),
    .MDOut(MDOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          busy_run = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name,
                           input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural rules.
  task automatic ref_op(input logic [3:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        inout logic [31:0] hi,
                        inout logic [31:0] lo,
                        output int cyc);
    longint          sa, sb, q, r, sp;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    cyc = (op <= 4'd2) ? MC : DC;
    case (op)
      4'd1: begin
        sp = sa * sb;
        hi = sp[63:32];
        lo = sp[31:0];
      end
      4'd2: begin
        up = longint'(a) * longint'(b);
        hi = up[63:32];
        lo = up[31:0];
      end
      4'd3: if (b != 0) begin
        q  = sa / sb;
        r  = sa % sb;
        lo = q[31:0];
        hi = r[31:0];
      end
      4'd4: if (b != 0) begin
        lo = a / b;
        hi = a % b;
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      busy_run = 0;
    end else if (Busy) begin
      busy_run++;
    end else if (busy_run > 0) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got busy end, expected none");
      end else begin
        e = exp_q.pop_front();
        check("done_hi", HI, e.hi);
        check("done_lo", LO, e.lo);
        check_int("busy_len", busy_run, e.cyc);
      end
      busy_run = 0;
    end
  end

  task automatic issue(input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    exp_t        e;
    logic [31:0] h, l;
    int          c;
    h = m_hi;
    l = m_lo;
    ref_op(op, a, b, h, l, c);
    e.hi = h;
    e.lo = l;
    e.cyc = c;
    exp_q.push_back(e);
    m_hi = h;
    m_lo = l;
    MDOp = op;
    Start = 1'b1;
    A = a;
    B = b;
    @(posedge clk);
    #1;
    Start = 1'b0;
    MDOp = 4'd0;
    A = $urandom;
    B = $urandom;
    check("busy_rise", {31'd0, Busy}, 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (Busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (Busy) begin
      tests++;
      fails++;
      $display("FAIL busy_timeout: got busy after %0d, expected idle", n);
    end
  endtask

  task automatic run_op(input logic [3:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b);
    issue(op, a, b);
    wait_idle();
  endtask

  initial begin : stim
    logic [31:0] old_hi, old_lo, ra, rb;
    logic [3:0]  rop;
    int          n;

    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_mdout", MDOut, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    run_op(4'd1, 32'hFFFFFFFF, 32'd2);
    check("mult_hi", HI, 32'hFFFFFFFF);
    check("mult_lo", LO, 32'hFFFFFFFE);

    run_op(4'd2, 32'hFFFFFFFF, 32'd2);
    check("multu_hi", HI, 32'h00000001);
    check("multu_lo", LO, 32'hFFFFFFFE);
    MDOp = 4'd5;
    #1;
    check("mfhi", MDOut, 32'h00000001);
    MDOp = 4'd6;
    #1;
    check("mflo", MDOut, 32'hFFFFFFFE);
    MDOp = 4'd0;
    #1;
    check("mdout_none", MDOut, 32'd0);

    run_op(4'd3, 32'hFFFFFFF9, 32'd2);
    check("div_lo", LO, 32'hFFFFFFFD);
    check("div_hi", HI, 32'hFFFFFFFF);
    run_op(4'd4, 32'd7, 32'd2);
    check("divu_lo", LO, 32'd3);
    check("divu_hi", HI, 32'd1);

    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF);
    check("ovf_lo", LO, 32'h80000000);
    check("ovf_hi", HI, 32'd0);
    run_op(4'd4, 32'd7, 32'd2);
    run_op(4'd3, 32'd5, 32'd0);
    check("dz_hi", HI, 32'd1);
    check("dz_lo", LO, 32'd3);
    run_op(4'd4, 32'd9, 32'd0);
    check("dzu_hi", HI, 32'd1);
    check("dzu_lo", LO, 32'd3);

    MDOp = 4'd7;
    A = 32'h12345678;
    @(posedge clk);
    #1;
    check("mthi_hi", HI, 32'h12345678);
    MDOp = 4'd8;
    A = 32'h9ABCDEF0;
    @(posedge clk);
    #1;
    MDOp = 4'd0;
    check("mtlo_lo", LO, 32'h9ABCDEF0);
    check("mtlo_hi", HI, 32'h12345678);
    check("mt_busy", {31'd0, Busy}, 32'd0);
    m_hi = 32'h12345678;
    m_lo = 32'h9ABCDEF0;

    // Start and mthi while busy must leave everything alone.
    old_hi = m_hi;
    old_lo = m_lo;
    issue(4'd1, 32'h00010003, 32'hFFFF0007);
    MDOp = 4'd3;
    Start = 1'b1;
    A = 32'd100;
    B = 32'd3;
    @(posedge clk);
    #1;
    check("intr_hi", HI, old_hi);
    check("intr_lo", LO, old_lo);
    Start = 1'b0;
    MDOp = 4'd7;
    A = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    MDOp = 4'd0;
    check("intr_mthi", HI, old_hi);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(1, 4));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: ra = 32'h80000000;
        2: rb = 32'hFFFFFFFF;
        3: rb = rb & 32'hF;
        default: ;
      endcase
      run_op(rop, ra, rb);
    end

    issue(4'd1, 32'h00001234, 32'h00005678);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    void'(exp_q.pop_back());
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    #2;
    reset = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("late_hi", HI, 32'd0);
    check("late_lo", LO, 32'd0);
    check("late_busy", {31'd0, Busy}, 32'd0);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending, expected 0",
               exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
